// File: rtl/paddsb_pkg.sv
// Shared types and constants for the sequential packed saturating nibble add.
// Lane geometry and saturation bounds live here so the ALU can reuse them.
package paddsb_pkg;

  localparam int LANE_W = 4;
  localparam int LANES  = 4;
  localparam int OP_W   = LANES * LANE_W;
  localparam int CNT_W  = $clog2(LANES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [LANE_W-1:0] SAT_MAX =
    {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] SAT_MIN =
    {1'b1, {(LANE_W-1){1'b0}}};

  function automatic logic [LANE_W-1:0] sat_bound(
    input logic neg
  );
    return neg ? SAT_MIN : SAT_MAX;
  endfunction

endpackage

// File: rtl/sat_add_lane.sv
// One signed saturating lane adder, shared over lanes by the sequencer.
// Overflow: operand signs agree while the raw sum sign differs.
module sat_add_lane
  import paddsb_pkg::*;
(
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  output logic [LANE_W-1:0] sum_o,
  output logic              ovf_o
);

  logic [LANE_W-1:0] raw;
  logic              sa;
  logic              sb;

  always_comb begin
    raw   = a_i + b_i;
    sa    = a_i[LANE_W-1];
    sb    = b_i[LANE_W-1];
    ovf_o = (sa == sb) && (raw[LANE_W-1] != sa);
    sum_o = ovf_o ? sat_bound(sa) : raw;
  end

endmodule

// File: rtl/paddsb_seq.sv
// PADDSB sequencer: one lane per clock through a shared saturating adder.
// start/busy/done handshake with a synchronous abort for flushes.
module paddsb_seq
  import paddsb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [OP_W-1:0] rs,
  input  logic [OP_W-1:0] rt,
  output logic            busy,
  output logic            done,
  output logic [OP_W-1:0] rd,
  output logic [LANES-1:0] sat
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  opa_q, opa_d;
  logic [OP_W-1:0]  opb_q, opb_d;
  logic [OP_W-1:0]  res_q, res_d;
  logic [LANES-1:0] flg_q, flg_d;
  logic [OP_W-1:0]  rd_q, rd_d;
  logic [LANES-1:0] sat_q, sat_d;
  logic             done_q, done_d;

  logic [LANE_W-1:0] lane_a;
  logic [LANE_W-1:0] lane_b;
  logic [LANE_W-1:0] lane_s;
  logic              lane_v;
  logic [OP_W-1:0]   res_mrg;
  logic [LANES-1:0]  flg_mrg;

  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        lane_a = opa_q[i*LANE_W +: LANE_W];
        lane_b = opb_q[i*LANE_W +: LANE_W];
      end
    end
  end

  sat_add_lane u_lane (
    .a_i   (lane_a),
    .b_i   (lane_b),
    .sum_o (lane_s),
    .ovf_o (lane_v)
  );

  // Working result with the current lane already merged in
  always_comb begin
    res_mrg = res_q;
    flg_mrg = flg_q;
    for (int i = 0; i < LANES; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        res_mrg[i*LANE_W +: LANE_W] = lane_s;
        flg_mrg[i] = lane_v;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    flg_d   = flg_q;
    rd_d    = rd_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          opa_d   = rs;
          opb_d   = rt;
          res_d   = '0;
          flg_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          res_d = res_mrg;
          flg_d = flg_mrg;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            rd_d    = res_mrg;
            sat_d   = flg_mrg;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      rd_q    <= '0;
      sat_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      rd_q    <= rd_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign rd   = rd_q;
  assign sat  = sat_q;

endmodule

// File: tb/tb_paddsb_seq.sv
// Self-checking bench for paddsb_seq against an integer lane model.
// Inputs driven and outputs sampled on the falling edge.
module tb_paddsb_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] rs;
  logic [15:0] rt;
  logic        busy;
  logic        done;
  logic [15:0] rd;
  logic [3:0]  sat;

  int checks = 0;
  int errors = 0;

  paddsb_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .rs    (rs),
    .rt    (rt),
    .busy  (busy),
    .done  (done),
    .rd    (rd),
    .sat   (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] r,
    output logic [3:0]  s
  );
    r = '0;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      int x;
      int y;
      int z;
      x = int'(a[i*4 +: 4]);
      y = int'(b[i*4 +: 4]);
      if (x > 7) x = x - 16;
      if (y > 7) y = y - 16;
      z = x + y;
      if (z > 7) begin
        z = 7;
        s[i] = 1'b1;
      end else if (z < -8) begin
        z = -8;
        s[i] = 1'b1;
      end
      r[i*4 +: 4] = 4'(z);
    end
  endfunction

  // Issue one op, scramble operands mid-op, watch up to 8 cycles.
  task automatic run_op(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] r,
    output logic [3:0]  s,
    output int          bcyc,
    output int          ndone,
    output int          lat
  );
    r = 'x;
    s = 'x;
    bcyc = 0;
    ndone = 0;
    lat = -1;
    @(negedge clk);
    rs = a;
    rt = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin
        rs = 16'($urandom);
        rt = 16'($urandom);
      end
      if (busy) bcyc++;
      if (done) begin
        ndone++;
        lat = k;
        r = rd;
        s = sat;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    rs = '0;
    rt = '0;
    #3;
    checks++;
    if ({busy, done, rd, sat} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b rd=%h sat=%b want all 0",
               busy, done, rd, sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [15:0] a[4];
    logic [15:0] b[4];
    logic [15:0] er[4];
    logic [3:0]  es[4];
    logic [15:0] r;
    logic [15:0] mr;
    logic [3:0]  s;
    logic [3:0]  ms;
    int bc;
    int nd;
    int lt;
    a = '{16'h1234, 16'h7777, 16'h8888, 16'h7F19};
    b = '{16'h2143, 16'h1111, 16'hFFFF, 16'h1892};
    er = '{16'h3377, 16'h7777, 16'h8888, 16'h0000};
    es = '{4'b0000, 4'b1111, 4'b1111, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      run_op(a[i], b[i], r, s, bc, nd, lt);
      model(a[i], b[i], mr, ms);
      checks++;
      if (r !== mr || s !== ms) begin
        errors++;
        $display("FAIL dir_model[%0d]: got rd=%h sat=%b want rd=%h sat=%b",
                 i, r, s, mr, ms);
      end
      if (i < 3) begin
        checks++;
        if (r !== er[i] || s !== es[i]) begin
          errors++;
          $display("FAIL dir_const[%0d]: got rd=%h sat=%b want rd=%h sat=%b",
                   i, r, s, er[i], es[i]);
        end
      end
      checks++;
      if (bc != 4 || nd != 1 || lt != 5) begin
        errors++;
        $display("FAIL dir_timing[%0d]: got busy=%0d done=%0d lat=%0d want 4 1 5",
                 i, bc, nd, lt);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [15:0] mr;
    logic [3:0]  s;
    logic [3:0]  ms;
    int bc;
    int nd;
    int lt;
    for (int i = 0; i < 25; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      run_op(a, b, r, s, bc, nd, lt);
      model(a, b, mr, ms);
      checks++;
      if (r !== mr || s !== ms || nd != 1 || bc != 4) begin
        errors++;
        $display("FAIL rand[%0d] %h+%h: got rd=%h sat=%b nd=%0d bc=%0d want rd=%h sat=%b 1 4",
                 i, a, b, r, s, nd, bc, mr, ms);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] mr;
    logic [3:0]  ms;
    int nd;
    model(16'h5A3C, 16'h2B71, mr, ms);
    nd = 0;
    @(negedge clk);
    rs = 16'h5A3C;
    rt = 16'h2B71;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 2 || k == 3) begin
        start = 1'b1;
        rs = 16'h8888;
        rt = 16'h8888;
      end else begin
        start = 1'b0;
      end
      if (done) nd++;
      @(negedge clk);
    end
    checks++;
    if (nd != 1 || rd !== mr || sat !== ms) begin
      errors++;
      $display("FAIL busy_ignore: got dones=%0d rd=%h sat=%b want 1 %h %b",
               nd, rd, sat, mr, ms);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] m1;
    logic [15:0] m2;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [15:0] r1;
    int per;
    int k;
    model(16'h1357, 16'h7531, m1, s1);
    model(16'hC0DE, 16'hBEEF, m2, s2);
    @(negedge clk);
    rs = 16'h1357;
    rt = 16'h7531;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 10) begin
      @(negedge clk);
      k++;
    end
    r1 = rd;
    rs = 16'hC0DE;
    rt = 16'hBEEF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b want 1", busy);
    end
    per = 1;
    while (!done && per < 12) begin
      @(negedge clk);
      per++;
    end
    checks++;
    if (per != 5 || r1 !== m1 || rd !== m2 || sat !== s2) begin
      errors++;
      $display("FAIL b2b: got per=%0d rd1=%h rd2=%h sat=%b want 5 %h %h %b",
               per, r1, rd, sat, m1, m2, s2);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [15:0] prev;
    logic [3:0]  psat;
    int nd;
    prev = rd;
    psat = sat;
    // abort sampled at E2
    rs = 16'h7777;
    rt = 16'h7777;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_mid: got busy=%b done=%b want 0 0", busy, done);
    end
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    checks++;
    if (nd != 0 || rd !== prev || sat !== psat) begin
      errors++;
      $display("FAIL abort_hold: got dones=%0d rd=%h sat=%b want 0 %h %b",
               nd, rd, sat, prev, psat);
    end
    // abort sampled at E4
    rs = 16'h8888;
    rt = 16'h8888;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rd !== prev || sat !== psat) begin
      errors++;
      $display("FAIL abort_last: got busy=%b done=%b rd=%h want 0 0 %h",
               busy, done, rd, prev);
    end
    // abort in IDLE blocks start
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b want 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] r;
    logic [15:0] mr;
    logic [3:0]  s;
    logic [3:0]  ms;
    int bc;
    int nd;
    int lt;
    int late;
    rs = 16'h4321;
    rt = 16'h1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, rd, sat} !== 22'd0) begin
      errors++;
      $display("FAIL rst_mid: got busy=%b done=%b rd=%h sat=%b want all 0",
               busy, done, rd, sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    late = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL rst_no_done: got dones=%0d want 0", late);
    end
    run_op(16'h6A05, 16'h0B7C, r, s, bc, nd, lt);
    model(16'h6A05, 16'h0B7C, mr, ms);
    checks++;
    if (r !== mr || s !== ms || nd != 1 || bc != 4) begin
      errors++;
      $display("FAIL rst_recover: got rd=%h sat=%b nd=%0d want %h %b 1",
               r, s, nd, mr, ms);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
